// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file constants. The same values are used by the register
// file and the decode stage, so they are kept here rather than in each module.
package regfile_wb_arbiter_pkg;

    localparam int WORDSIZE_DEF = 32;  // register data width
    localparam int REGS_DEF     = 32;  // architectural registers
    localparam int AW_DEF       = 5;   // register address width
    localparam int NREQ_DEF     = 3;   // writeback sources: ALU, load, mul/div
    localparam int X0           = 0;   // hardwired-zero register index

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus and issue-stage claim bus.
//   master : writeback sources and issue stage (drive valid/addr/data, claims)
//   slave  : regfile_wb_arbiter (returns one-hot req_ready and claim_ready)
// Requester i occupies req_addr[i*AW +: AW] and req_data[i*WORDSIZE +: WORDSIZE].
interface regfile_wb_arbiter_if
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NREQ     = NREQ_DEF,
    parameter int AW       = AW_DEF,
    parameter int WORDSIZE = WORDSIZE_DEF
);
    logic [NREQ-1:0]          req_valid;
    logic [NREQ*AW-1:0]       req_addr;
    logic [NREQ*WORDSIZE-1:0] req_data;
    logic [NREQ-1:0]          req_ready;
    logic                     claim_valid;
    logic [AW-1:0]            claim_addr;
    logic                     claim_ready;

    modport master (
        output req_valid, req_addr, req_data, claim_valid, claim_addr,
        input  req_ready, claim_ready
    );

    modport slave (
        input  req_valid, req_addr, req_data, claim_valid, claim_addr,
        output req_ready, claim_ready
    );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter for the register-file write port.
// Ports:
//   clk, rst : clock, async active-low reset
//   req      : request vector (one bit per writeback source)
//   gnt      : one-hot grant, zero when nothing is requested
//   gnt_idx  : index of the granted requester (valid when gnt_vld)
//   gnt_vld  : any grant this cycle
// The grant is a pure function of req and rr_ptr, so no requester's grant
// depends on another requester's grant.
module regfile_wb_arbiter_rr_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx,
    output logic            gnt_vld
);

    logic [IW-1:0] rr_ptr;

    // Walk offsets from highest to lowest so the candidate closest to rr_ptr
    // (offset 0) is the last one written and therefore wins.
    always_comb begin
        int idx;
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                gnt_idx  = IW'(idx);
                gnt_vld  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rr_ptr <= '0;
        else if (gnt_vld)
            rr_ptr <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the single register-file write port among NREQ writeback sources and
// keeps the busy scoreboard used by decode for RAW/WAW stalls.
// Ports:
//   clk, rst  : clock, async active-low reset
//   bus       : request/claim bus (slave side)
//   rf_we     : register-file write enable, one cycle after the handshake
//   rf_saddr  : register-file write address (registered)
//   rf_wdata  : register-file write data (registered)
//   busy      : bit r set while a claimed write to r is outstanding
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int WORDSIZE = WORDSIZE_DEF,
    parameter int REGS     = REGS_DEF,
    parameter int AW       = AW_DEF,
    parameter int NREQ     = NREQ_DEF
) (
    input  logic                clk,
    input  logic                rst,
    regfile_wb_arbiter_if.slave bus,
    output logic                rf_we,
    output logic [AW-1:0]       rf_saddr,
    output logic [WORDSIZE-1:0] rf_wdata,
    output logic [REGS-1:0]     busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef struct packed {
        logic                we;
        logic [AW-1:0]       addr;
        logic [WORDSIZE-1:0] data;
    } wb_t;

    logic [NREQ-1:0]     gnt;
    logic [IW-1:0]       gnt_idx;
    logic                gnt_vld;
    logic [AW-1:0]       sel_addr;
    logic [WORDSIZE-1:0] sel_data;
    logic                claim_in_range;
    logic [REGS-1:0]     busy_nxt;
    wb_t                 wb_q;

    regfile_wb_arbiter_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req_valid),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign bus.req_ready = gnt;

    always_comb begin
        sel_addr = bus.req_addr[int'(gnt_idx)*AW +: AW];
        sel_data = bus.req_data[int'(gnt_idx)*WORDSIZE +: WORDSIZE];
    end

    // A granted write to x0 still completes the handshake and updates the
    // address/data pins, but never asserts the write enable. With no grant
    // only the enable drops; address/data hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_q <= '0;
        end else if (gnt_vld) begin
            wb_q.we   <= (sel_addr != AW'(X0));
            wb_q.addr <= sel_addr;
            wb_q.data <= sel_data;
        end else begin
            wb_q.we <= 1'b0;
        end
    end

    assign rf_we    = wb_q.we;
    assign rf_saddr = wb_q.addr;
    assign rf_wdata = wb_q.data;

    // Out-of-range addresses are refused; x0 is never busy so its claim is
    // always accepted and simply has no effect.
    assign claim_in_range  = (int'(bus.claim_addr) < REGS);
    assign bus.claim_ready = claim_in_range && !busy[bus.claim_addr];

    // Clear for the write retiring this cycle first, then the new claim, so a
    // set and clear of the same register at one edge leaves it set.
    always_comb begin
        busy_nxt = busy;
        if (rf_we)
            busy_nxt[rf_saddr] = 1'b0;
        if (bus.claim_valid && bus.claim_ready && bus.claim_addr != AW'(X0))
            busy_nxt[bus.claim_addr] = 1'b1;
        busy_nxt[X0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench: stimulus pushes the hand-computed expected writes into a
// queue; a monitor pops one entry per cycle in which rf_we is high.
module tb_regfile_wb_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int WS   = 32;
    localparam int REGS = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            rf_we;
    logic [AW-1:0]   rf_saddr;
    logic [WS-1:0]   rf_wdata;
    logic [REGS-1:0] busy;

    regfile_wb_arbiter_if #(.NREQ(NREQ), .AW(AW), .WORDSIZE(WS)) bus ();

    regfile_wb_arbiter #(.WORDSIZE(WS), .REGS(REGS), .AW(AW), .NREQ(NREQ)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .rf_we    (rf_we),
        .rf_saddr (rf_saddr),
        .rf_wdata (rf_wdata),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [WS-1:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [WS-1:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [WS-1:0] d);
        bus.req_valid[i]          = v;
        bus.req_addr[i*AW +: AW]  = a;
        bus.req_data[i*WS +: WS]  = d;
    endtask

    task automatic set_claim(input logic v, input logic [AW-1:0] a);
        bus.claim_valid = v;
        bus.claim_addr  = a;
    endtask

    // Start of a cycle (drive point) and middle of a cycle (sample point).
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        set_claim(1'b0, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Write monitor: every enabled write must match the next expected entry.
    always @(negedge clk) begin
        if (rst && rf_we) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got addr %0d data %h, expected none at %0t",
                         rf_saddr, rf_wdata, $time);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(rf_saddr), 32'(e.a));
                chk("wr_data", rf_wdata, e.d);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        logic [AW-1:0] a3 [3];
        logic [WS-1:0] d3 [3];
        a3 = '{5'd1, 5'd2, 5'd3};
        d3 = '{32'hA0, 32'hB1, 32'hC2};

        // ---- reset state
        do_reset();
        smp();
        chk("rst_we",    32'(rf_we), 32'd0);
        chk("rst_saddr", 32'(rf_saddr), 32'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        chk("rst_busy",  busy, 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("x0_claim",  32'(bus.claim_ready), 32'd1);

        // ---- single request, one-cycle latency
        nxt();
        set_req(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        push(5'd5, 32'hDEAD_BEEF);
        smp();
        chk("single_ready", 32'(bus.req_ready), 32'b001);
        nxt();
        set_req(0, 1'b0, 5'd0, 32'd0);
        smp();
        chk("single_we1", 32'(rf_we), 32'd1);
        nxt();
        smp();
        chk("single_we0", 32'(rf_we), 32'd0);

        // ---- all three continuously valid: 0,1,2,0,1,2 back-to-back
        do_reset();
        nxt();
        for (int i = 0; i < 3; i++) set_req(i, 1'b1, a3[i], d3[i]);
        for (int k = 0; k < 6; k++) begin
            smp();
            chk("rr_gnt", 32'(bus.req_ready), 32'(1) << (k % 3));
            push(a3[k%3], d3[k%3]);
            if (k > 0) chk("rr_we", 32'(rf_we), 32'd1);
            nxt();
        end
        bus.req_valid = '0;
        smp();
        chk("rr_we_last", 32'(rf_we), 32'd1);
        nxt();
        smp();
        chk("rr_we_idle", 32'(rf_we), 32'd0);

        // ---- write to x0: handshake, no enable, pointer still advances
        do_reset();
        nxt();
        set_req(1, 1'b1, 5'd0, 32'h1234);
        smp();
        chk("x0_ready", 32'(bus.req_ready), 32'b010);
        nxt();
        set_req(1, 1'b0, 5'd0, 32'd0);
        set_req(0, 1'b1, 5'd12, 32'h5555);
        set_req(2, 1'b1, 5'd13, 32'h6666);
        smp();
        chk("x0_we",    32'(rf_we), 32'd0);
        chk("x0_saddr", 32'(rf_saddr), 32'd0);
        chk("x0_wdata", rf_wdata, 32'h1234);
        chk("x0_ptr2",  32'(bus.req_ready), 32'b100);
        push(5'd13, 32'h6666);
        nxt();
        set_req(2, 1'b0, 5'd0, 32'd0);
        smp();
        chk("x0_wrap0", 32'(bus.req_ready), 32'b001);
        push(5'd12, 32'h5555);
        nxt();
        set_req(0, 1'b0, 5'd0, 32'd0);
        nxt();

        // ---- claim / write / clear of x7
        do_reset();
        nxt();
        set_claim(1'b1, 5'd7);
        smp();
        chk("c7_ready1", 32'(bus.claim_ready), 32'd1);
        nxt();
        smp();
        chk("c7_busy",   32'(busy[7]), 32'd1);
        chk("c7_ready2", 32'(bus.claim_ready), 32'd0);
        nxt();
        set_claim(1'b0, 5'd0);
        set_req(2, 1'b1, 5'd7, 32'h77);
        push(5'd7, 32'h77);
        smp();
        chk("c7_gnt", 32'(bus.req_ready), 32'b100);
        nxt();
        set_req(2, 1'b0, 5'd0, 32'd0);
        smp();
        chk("c7_we",    32'(rf_we), 32'd1);
        chk("c7_still", 32'(busy[7]), 32'd1);
        nxt();
        smp();
        chk("c7_clear", 32'(busy[7]), 32'd0);

        // ---- x9 claim colliding with its own retiring write
        do_reset();
        nxt();
        set_claim(1'b1, 5'd9);
        nxt();
        set_claim(1'b0, 5'd0);
        set_req(0, 1'b1, 5'd9, 32'h99);
        push(5'd9, 32'h99);
        nxt();
        set_req(0, 1'b0, 5'd0, 32'd0);
        set_claim(1'b1, 5'd9);
        smp();
        chk("c9_busy_we", 32'(busy[9]), 32'd1);
        chk("c9_refused", 32'(bus.claim_ready), 32'd0);
        nxt();
        set_claim(1'b0, 5'd0);
        set_req(0, 1'b1, 5'd9, 32'h98);
        push(5'd9, 32'h98);
        smp();
        chk("c9_cleared", 32'(busy[9]), 32'd0);
        nxt();
        set_req(0, 1'b0, 5'd0, 32'd0);
        set_claim(1'b1, 5'd9);
        smp();
        chk("c9_accept", 32'(bus.claim_ready), 32'd1);
        nxt();
        set_claim(1'b0, 5'd0);
        smp();
        chk("c9_setwins", 32'(busy[9]), 32'd1);

        // ---- asynchronous reset mid-stream
        do_reset();
        for (int r = 8; r < 12; r++) begin
            nxt();
            set_claim(1'b1, 5'(r));
        end
        nxt();
        set_claim(1'b0, 5'd0);
        set_req(0, 1'b1, 5'd3, 32'h3333);
        push(5'd3, 32'h3333);
        smp();
        chk("ar_busy_pre", busy, 32'h0000_0F00);
        nxt();
        set_req(0, 1'b0, 5'd0, 32'd0);
        smp();
        chk("ar_we_pre", 32'(rf_we), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("ar_we",    32'(rf_we), 32'd0);
        chk("ar_saddr", 32'(rf_saddr), 32'd0);
        chk("ar_wdata", rf_wdata, 32'd0);
        chk("ar_busy",  busy, 32'd0);
        do_reset();
        nxt();

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
